forney_eval: RTL and testbench
==============================

# forney_eval

Parametrised Forney error-value evaluator for the GF(2^8) Reed-Solomon decoders (RS(255,247) and wider-T variants). It sits between the Chien search and the correction stage. It takes the error locators X_k, the error-locator polynomial Λ and the error-evaluator polynomial Ω. For each located error it streams out the error magnitude e_k = X_k^(1−FCR)·Ω(X_k⁻¹)/Λ′(X_k⁻¹), using one inverter and two multipliers time-shared across all errors. It also flags uncorrectable words.

## Interface
- T, 4, max correctable errors (≥1); polynomial and locator array sizes follow from it
- FCR, 1, first consecutive root of the code generator, 0 or 1
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle request; ignored while busy=1
- error_num  in  $clog2(T+2)  number of valid locators (as counted by Chien search)
- el  in  T*8  locators X_0..X_{T−1}, X_k at [8k+7:8k]
- lambda  in  (T+1)*8  Λ coefficients λ_0..λ_T, λ_i at [8i+7:8i]
- omega  in  T*8  Ω coefficients ω_0..ω_{T−1}
- busy  out  1  evaluation in progress
- ev_valid  out  1  ev_idx/ev_data valid this cycle
- ev_idx  out  max(1,$clog2(T))  index k of the current error
- ev_data  out  8  error magnitude e_k
- done  out  1  one-cycle pulse, word finished
- fail  out  1  valid with done; word uncorrectable

## Operation
- Field: GF(2^8) with primitive polynomial 0x11D. Add is XOR. 0⁻¹ is defined as 0.
- On an accepted start, capture el, lambda, omega and error_num into internal registers. Upstream may change them the next cycle.
- error_num=0: no ev_valid; done=1, fail=0.
- error_num>T: no ev_valid; done=1, fail=1.
- Otherwise, for k=0..error_num−1, run these FSM states:
  - INV: xi ← X_k⁻¹.
  - SQ: x2 ← xi·xi.
  - EVAL (T cycles, i=T−1..0):
    - Multiplier A computes num ← num·xi ⊕ ω_i, with num cleared on entry.
    - Multiplier B, in the first m=ceil(T/2) cycles, computes den ← den·x2 ⊕ λ_{2j+1} for j=m−1..0. This is Λ′ for characteristic 2.
  - DIV: dinv ← den⁻¹. If FCR=0, multiplier A computes num ← num·X_k in the same cycle.
  - MUL: ev_data ← num·dinv, ev_idx ← k, ev_valid ← 1.
- If den=0, emit ev_data=0, set sticky fail, and continue with the remaining errors.
- X_k=0 is treated the same way as den=0.
- IDLE is entered after the last MUL.
- States: IDLE → INV → SQ → EVAL → DIV → MUL → (INV for next k | IDLE).

## Timing
- Reset values: busy, ev_valid, ev_idx, ev_data, done, fail are all 0; the FSM is in IDLE.
- start is sampled on edge E0. busy=1 from E0+1 until the cycle done is asserted.
- Per-error period: P = T+4 cycles.
- ev_valid for error k is high for exactly one cycle, the cycle after edge E0+(k+1)·P.
- done and the final fail are asserted in the same cycle as the last ev_valid. busy drops in that same cycle.
- For error_num=0 or error_num>T, done is asserted in the cycle after E0.
- A start coincident with done is ignored. The next start is accepted when busy=0.
- fail clears on an accepted start.
- rst_n=0 mid-word aborts immediately to the reset state. No done is produced for the aborted word.
- Default T=4: P=8, so a 4-error word completes 32 cycles after start.

## Structure
- Shared package rs_gf_pkg holds:
  - GF_W=8 and GF_POLY=8'h1D.
  - Function gf_idx_w(T) for the ev_idx width.
  - The FSM state enum.
- Reuse the existing gf256mul (×2) and gf256inv (×1) combinational cells.
- No further sub-module is needed. The FSM, counters (k, i) and datapath live in forney_eval.

## Test plan
- T=4, FCR=1, error_num=1, el[0]=0x02, lambda={1,0x02,0,0,0}, omega={0xB4,0,0,0} → one ev_valid 9 cycles after start with ev_idx=0, ev_data=0x5A; done=1 and fail=0 in that cycle.
- T=4, FCR=0, same el/lambda, omega={0x5A,0,0,0} → ev_data=0x5A, fail=0.
- T=4, error_num=4 with locators/polynomials from a software model on random codewords → four ev_valid pulses 8 cycles apart, values match the model; done on the 4th pulse, 32 cycles after start.
- error_num=0 → done the cycle after start, fail=0, no ev_valid. error_num=5 with T=4 → done with fail=1, no ev_valid.
- error_num=2, lambda odd terms all zero → two ev_valid with ev_data=0; done with fail=1.
- Stalls and aborts:
  - start pulsed while busy → ignored, output sequence unchanged.
  - rst_n=0 for one cycle mid-EVAL → all outputs 0 next cycle, no done.
  - A new start then completes normally.

Source files
------------

// File: rtl/rs_gf_pkg.sv
// rs_gf_pkg: GF(2^8) constants, helpers and FSM state type shared by the
// Reed-Solomon decoder blocks.
//   GF_W      symbol width
//   GF_POLY   low byte of the primitive polynomial 0x11D
//   gf_idx_w  width of an error index for a given T (never below 1)
//   gf_mul    combinational GF(2^8) product (shift-and-add, reduce on overflow)
//   fe_state_e  forney_eval sequencer states
package rs_gf_pkg;

  localparam int GF_W = 8;
  localparam logic [GF_W-1:0] GF_POLY = 8'h1D;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INV  = 3'd1,
    ST_SQ   = 3'd2,
    ST_EVAL = 3'd3,
    ST_DIV  = 3'd4,
    ST_MUL  = 3'd5
  } fe_state_e;

  function automatic int gf_idx_w(input int t);
    return (t <= 2) ? 1 : $clog2(t);
  endfunction

  function automatic logic [GF_W-1:0] gf_mul(input logic [GF_W-1:0] a,
                                            input logic [GF_W-1:0] b);
    logic [GF_W-1:0] acc;
    logic [GF_W-1:0] sh;
    acc = '0;
    sh  = a;
    for (int n = 0; n < GF_W; n++) begin
      if (b[n]) acc = acc ^ sh;
      // multiply sh by alpha, folding x^8 back through the polynomial
      sh = {sh[GF_W-2:0], 1'b0} ^ ({GF_W{sh[GF_W-1]}} & GF_POLY);
    end
    return acc;
  endfunction

endpackage

// File: rtl/forney_eval_if.sv
// forney_eval_if: request/result bundle of the Forney evaluator.
//   start, error_num, el, lambda, omega   requester -> evaluator
//   busy, ev_valid, ev_idx, ev_data,
//   done, fail, dbg_state                 evaluator -> requester
// Handshake: start is a one-cycle request, taken only while the evaluator is
// idle and not in its done cycle; the data inputs are sampled on that same
// edge only. ev_valid is a one-cycle strobe with no backpressure: ev_idx and
// ev_data are meaningful only while it is high. done is a one-cycle pulse that
// closes a word and fail is meaningful in that cycle.
interface forney_eval_if
  import rs_gf_pkg::*;
#(
  parameter int T = 4
) ();
  localparam int EW = $clog2(T + 2);
  localparam int IW = gf_idx_w(T);

  logic                   start;
  logic [EW-1:0]          error_num;
  logic [T*GF_W-1:0]      el;
  logic [(T+1)*GF_W-1:0]  lambda;
  logic [T*GF_W-1:0]      omega;
  logic                   busy;
  logic                   ev_valid;
  logic [IW-1:0]          ev_idx;
  logic [GF_W-1:0]        ev_data;
  logic                   done;
  logic                   fail;
  fe_state_e              dbg_state;

  modport master (
    output start, error_num, el, lambda, omega,
    input  busy, ev_valid, ev_idx, ev_data, done, fail, dbg_state
  );

  modport slave (
    input  start, error_num, el, lambda, omega,
    output busy, ev_valid, ev_idx, ev_data, done, fail, dbg_state
  );
endinterface

// File: rtl/gf256inv.sv
// gf256inv: combinational GF(2^8) inverter, a^-1 = a^254; 0 maps to 0.
//   a_i    operand
//   inv_o  multiplicative inverse
module gf256inv
  import rs_gf_pkg::*;
(
  input  logic [GF_W-1:0] a_i,
  output logic [GF_W-1:0] inv_o
);
  logic [GF_W-1:0] sq;
  logic [GF_W-1:0] acc;

  // 254 = 2+4+...+128: accumulate the seven successive squares of a.
  always_comb begin
    sq  = a_i;
    acc = 8'h01;
    for (int n = 0; n < 7; n++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    inv_o = acc;
  end
endmodule

// File: rtl/gf256mul.sv
// gf256mul: combinational GF(2^8) multiplier.
//   a_i, b_i  operands
//   p_o       a_i * b_i mod 0x11D
module gf256mul
  import rs_gf_pkg::*;
(
  input  logic [GF_W-1:0] a_i,
  input  logic [GF_W-1:0] b_i,
  output logic [GF_W-1:0] p_o
);
  always_comb begin
    p_o = gf_mul(a_i, b_i);
  end
endmodule

// File: rtl/forney_eval.sv
// forney_eval: Forney error-value evaluator for GF(2^8) Reed-Solomon decoders.
// For each located error k it streams e_k = X_k^(1-FCR)*Omega(X_k^-1)/Lambda'(X_k^-1)
// using one inverter and two multipliers shared over all errors (T+4 cycles
// per error). Words with more than T errors, a zero locator or a zero
// derivative are flagged with fail.
//   clk, rst_n  clock, synchronous active-low reset
//   io          forney_eval_if slave: request inputs, result stream, debug state
module forney_eval
  import rs_gf_pkg::*;
#(
  parameter int T   = 4,
  parameter int FCR = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  forney_eval_if.slave io
);
  localparam int EW = $clog2(T + 2);
  localparam int IW = gf_idx_w(T);
  localparam int M  = (T + 1) / 2;
  // EVAL cycle index at which the derivative accumulation starts
  localparam logic [IW-1:0] DEN_FIRST = IW'(T - M);

  fe_state_e state_q, state_d;

  logic [IW-1:0]   k_q, i_q;
  logic [EW-1:0]   num_err_q;
  logic [GF_W-1:0] el_q      [0:T-1];
  logic [GF_W-1:0] om_q      [0:T-1];
  logic [GF_W-1:0] lam_odd_q [0:M-1];
  logic [GF_W-1:0] xi_q, x2_q, acc_q, den_q, dinv_q;
  logic            fail_q, done_q, ev_valid_q;
  logic [IW-1:0]   ev_idx_q;
  logic [GF_W-1:0] ev_data_q;

  logic            accept, range_ok, last, den_act, bad;
  logic [IW-1:0]   jj;
  logic [GF_W-1:0] xk, om_sel, lam_sel;
  logic [GF_W-1:0] mul_a_x, mul_a_y, mul_a_p, mul_b_p, inv_in, inv_p;
  logic            lam_even_unused;

  // A start in the done cycle is dropped so a word is never re-launched by a
  // request that overlapped the end of the previous one.
  assign accept   = io.start && (state_q == ST_IDLE) && !done_q;
  assign range_ok = (io.error_num != '0) && (io.error_num <= EW'(T));
  assign last     = (EW'(k_q) + EW'(1)) == num_err_q;
  assign den_act  = (i_q >= DEN_FIRST);
  assign jj       = i_q - DEN_FIRST;
  assign bad      = (den_q == '0) || (xk == '0);

  // Only odd Lambda coefficients feed the formal derivative.
  always_comb begin
    lam_even_unused = 1'b0;
    for (int j = 0; j <= T; j += 2) lam_even_unused = lam_even_unused ^ (^io.lambda[GF_W*j +: GF_W]);
  end

  always_comb begin
    xk      = '0;
    om_sel  = '0;
    lam_sel = '0;
    for (int n = 0; n < T; n++) begin
      if (IW'(n) == k_q) xk = el_q[n];
      if (IW'(n) == i_q) om_sel = om_q[n];
    end
    for (int j = 0; j < M; j++) begin
      if (IW'(j) == jj) lam_sel = lam_odd_q[j];
    end
  end

  // Multiplier A is time-shared: square, Horner step, X_k scaling, final divide.
  always_comb begin
    mul_a_x = acc_q;
    mul_a_y = '0;
    unique case (state_q)
      ST_SQ:   begin mul_a_x = xi_q; mul_a_y = xi_q; end
      ST_EVAL: mul_a_y = xi_q;
      ST_DIV:  mul_a_y = xk;
      ST_MUL:  mul_a_y = dinv_q;
      default: ;
    endcase
  end

  assign inv_in = (state_q == ST_DIV) ? den_q : xk;

  gf256mul u_mul_a (.a_i(mul_a_x), .b_i(mul_a_y), .p_o(mul_a_p));
  gf256mul u_mul_b (.a_i(den_q),   .b_i(x2_q),    .p_o(mul_b_p));
  gf256inv u_inv   (.a_i(inv_in),  .inv_o(inv_p));

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept && range_ok) state_d = ST_INV;
      ST_INV:  state_d = ST_SQ;
      ST_SQ:   state_d = ST_EVAL;
      ST_EVAL: if (i_q == '0) state_d = ST_DIV;
      ST_DIV:  state_d = ST_MUL;
      ST_MUL:  state_d = last ? ST_IDLE : ST_INV;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    io.busy      = (state_q != ST_IDLE);
    io.dbg_state = state_q;
    io.ev_valid  = ev_valid_q;
    io.ev_idx    = ev_idx_q;
    io.ev_data   = ev_data_q;
    io.done      = done_q;
    io.fail      = fail_q;
  end

  // Datapath and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_q        <= '0;
      i_q        <= '0;
      num_err_q  <= '0;
      xi_q       <= '0;
      x2_q       <= '0;
      acc_q      <= '0;
      den_q      <= '0;
      dinv_q     <= '0;
      fail_q     <= 1'b0;
      done_q     <= 1'b0;
      ev_valid_q <= 1'b0;
      ev_idx_q   <= '0;
      ev_data_q  <= '0;
      for (int n = 0; n < T; n++) begin
        el_q[n] <= '0;
        om_q[n] <= '0;
      end
      for (int j = 0; j < M; j++) lam_odd_q[j] <= '0;
    end else begin
      ev_valid_q <= 1'b0;
      done_q     <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            for (int n = 0; n < T; n++) begin
              el_q[n] <= io.el[GF_W*n +: GF_W];
              om_q[n] <= io.omega[GF_W*n +: GF_W];
            end
            for (int j = 0; j < M; j++) lam_odd_q[j] <= io.lambda[GF_W*(2*j+1) +: GF_W];
            num_err_q <= io.error_num;
            k_q       <= '0;
            fail_q    <= (io.error_num > EW'(T));
            done_q    <= !range_ok;
          end
        end
        ST_INV: xi_q <= inv_p;
        ST_SQ: begin
          x2_q  <= mul_a_p;
          acc_q <= '0;
          den_q <= '0;
          i_q   <= IW'(T - 1);
        end
        ST_EVAL: begin
          acc_q <= mul_a_p ^ om_sel;
          if (den_act) den_q <= mul_b_p ^ lam_sel;
          i_q <= i_q - IW'(1);
        end
        ST_DIV: begin
          dinv_q <= inv_p;
          if (FCR == 0) acc_q <= mul_a_p;
        end
        ST_MUL: begin
          ev_valid_q <= 1'b1;
          ev_idx_q   <= k_q;
          if (bad) begin
            ev_data_q <= '0;
            fail_q    <= 1'b1;
          end else begin
            ev_data_q <= mul_a_p;
          end
          if (last) done_q <= 1'b1;
          else      k_q    <= k_q + IW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_forney_eval.sv
// tb_forney_eval: drives two evaluators (FCR=1 and FCR=0) with the same
// locators/Lambda and FCR-specific Omega, and checks the result stream,
// timing, done/fail and abort behaviour against an expected queue.
module tb_forney_eval;
  import rs_gf_pkg::*;

  localparam int T  = 4;
  localparam int P  = T + 4;
  localparam int EW = $clog2(T + 2);
  localparam int IW = gf_idx_w(T);
  localparam int W  = 32 + IW + 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  forney_eval_if #(.T(T)) bus1 ();
  forney_eval_if #(.T(T)) bus0 ();

  forney_eval #(.T(T), .FCR(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .io(bus1));
  forney_eval #(.T(T), .FCR(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .io(bus0));

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp1_q[$];
  logic [W-1:0] exp0_q[$];
  int   exp_done_cyc = -1;
  logic exp_fail = 1'b0;
  bit   done_seen1, done_seen0;

  logic [7:0] el_a  [T];
  logic [7:0] lam_a [T+1];
  logic [7:0] om1_a [T];
  logic [7:0] om0_a [T];
  logic [7:0] ex_a  [T];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference GF arithmetic ----------------
  function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int n = 0; n < 8; n++) if (b[n]) p = p ^ (15'(a) << n);
    for (int n = 14; n >= 8; n--) if (p[n]) p = p ^ (15'(9'h11D) << (n - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] tb_pow(input logic [7:0] a, input int e);
    logic [7:0] r;
    r = 8'h01;
    for (int n = 0; n < e; n++) r = tb_mul(r, a);
    return r;
  endfunction

  // Lambda = prod(1 + X_k x); Omega = S(x)*Lambda(x) mod x^2T with
  // S_j = sum e_k X_k^(j+FCR). Forney must then return the injected e_k.
  task automatic build_word(input int n);
    logic [7:0] s1 [2*T];
    logic [7:0] s0 [2*T];
    for (int i = 0; i <= T; i++) lam_a[i] = (i == 0) ? 8'h01 : 8'h00;
    for (int k = 0; k < n; k++)
      for (int i = T; i >= 1; i--) lam_a[i] = lam_a[i] ^ tb_mul(el_a[k], lam_a[i-1]);
    for (int j = 0; j < 2*T; j++) begin
      s1[j] = 8'h00;
      s0[j] = 8'h00;
      for (int k = 0; k < n; k++) begin
        s1[j] = s1[j] ^ tb_mul(ex_a[k], tb_pow(el_a[k], j + 1));
        s0[j] = s0[j] ^ tb_mul(ex_a[k], tb_pow(el_a[k], j));
      end
    end
    for (int i = 0; i < T; i++) begin
      om1_a[i] = 8'h00;
      om0_a[i] = 8'h00;
      for (int a = 0; a <= i; a++) begin
        om1_a[i] = om1_a[i] ^ tb_mul(s1[a], lam_a[i-a]);
        om0_a[i] = om0_a[i] ^ tb_mul(s0[a], lam_a[i-a]);
      end
    end
  endtask

  task automatic random_word(input int n);
    int  p [T];
    bit  dup;
    for (int k = 0; k < T; k++) begin
      if (k < n) begin
        do begin
          p[k] = $urandom_range(0, 254);
          dup = 1'b0;
          for (int j = 0; j < k; j++) if (p[j] == p[k]) dup = 1'b1;
        end while (dup);
        el_a[k] = tb_pow(8'h02, p[k]);
        ex_a[k] = 8'($urandom_range(1, 255));
      end else begin
        el_a[k] = 8'($urandom_range(0, 255));
        ex_a[k] = 8'h00;
      end
    end
    build_word(n);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_inputs(input int n);
    bus1.error_num = EW'(n);
    bus0.error_num = EW'(n);
    for (int k = 0; k < T; k++) begin
      bus1.el[8*k +: 8]    = el_a[k];
      bus0.el[8*k +: 8]    = el_a[k];
      bus1.omega[8*k +: 8] = om1_a[k];
      bus0.omega[8*k +: 8] = om0_a[k];
    end
    for (int k = 0; k <= T; k++) begin
      bus1.lambda[8*k +: 8] = lam_a[k];
      bus0.lambda[8*k +: 8] = lam_a[k];
    end
  endtask

  task automatic pulse_start();
    bus1.start = 1'b1;
    bus0.start = 1'b1;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    bus0.start = 1'b0;
  endtask

  // mode 0: plain word; 1: extra start with scrambled inputs while busy;
  // 2: extra start in the done cycle (immediate-done words only)
  task automatic run_word(input int n, input logic exp_fail_i, input int mode);
    int e0, dc;
    bit in_range;
    in_range = (n > 0) && (n <= T);
    drive_inputs(n);
    e0 = cyc + 1;
    dc = in_range ? e0 + n * P : e0;
    if (in_range)
      for (int k = 0; k < n; k++) begin
        exp1_q.push_back({32'(e0 + (k + 1) * P), IW'(k), ex_a[k]});
        exp0_q.push_back({32'(e0 + (k + 1) * P), IW'(k), ex_a[k]});
      end
    exp_fail     = exp_fail_i;
    exp_done_cyc = dc;
    done_seen1   = 1'b0;
    done_seen0   = 1'b0;
    pulse_start();
    check("busy_after_start", {bus1.busy, bus0.busy}, {2{in_range}});
    if (mode == 1) begin
      repeat (3) @(posedge clk);
      #1;
      bus1.error_num = '0;
      bus0.error_num = '0;
      bus1.el = {T{8'($urandom_range(0, 255))}};
      bus0.el = bus1.el;
      bus1.lambda = '0;
      bus0.lambda = '0;
      bus1.omega = {T{8'($urandom_range(0, 255))}};
      bus0.omega = bus1.omega;
      pulse_start();
    end
    if (mode == 2) begin
      bus1.error_num = EW'(1);
      bus0.error_num = EW'(1);
      pulse_start();
      check("start_at_done_busy", {bus1.busy, bus0.busy}, 2'b00);
      check("start_at_done_state", bus1.dbg_state, ST_IDLE);
    end
    while (!(done_seen1 && done_seen0) && cyc <= dc + 2) begin
      @(posedge clk); #1;
    end
    check("done_timeout", {done_seen1, done_seen0}, 2'b11);
    repeat (3) @(posedge clk);
    #1;
    check("pending_exp", exp1_q.size() + exp0_q.size(), 0);
  endtask

  task automatic run_abort(input int n);
    random_word(n);
    drive_inputs(n);
    exp_done_cyc = -1;
    pulse_start();
    repeat (4) @(posedge clk);
    #1;
    check("abort_in_eval", bus1.dbg_state, ST_EVAL);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_busy",    {bus1.busy, bus0.busy}, 2'b00);
    check("abort_valid",   {bus1.ev_valid, bus0.ev_valid}, 2'b00);
    check("abort_done",    {bus1.done, bus0.done}, 2'b00);
    check("abort_fail",    {bus1.fail, bus0.fail}, 2'b00);
    check("abort_ev_data", {bus1.ev_data, bus0.ev_data}, 16'h0000);
    check("abort_state",   bus1.dbg_state, ST_IDLE);
    rst_n = 1'b1;
    repeat (3 * P) @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  task automatic mon(input int which, input logic v, input logic [IW-1:0] idx,
                     input logic [7:0] d, input logic dn, input logic fl, input logic bsy);
    logic [W-1:0] e;
    int pend;
    if (v) begin
      pend = (which == 1) ? exp1_q.size() : exp0_q.size();
      if (pend == 0) begin
        check($sformatf("dut%0d_ev_unexpected", which), v, 1'b0);
      end else begin
        if (which == 1) e = exp1_q.pop_front();
        else            e = exp0_q.pop_front();
        check($sformatf("dut%0d_ev_cycle", which), cyc, e[W-1 -: 32]);
        check($sformatf("dut%0d_ev_idx", which), idx, e[8 +: IW]);
        check($sformatf("dut%0d_ev_data", which), d, e[7:0]);
      end
    end
    if (dn) begin
      pend = (which == 1) ? exp1_q.size() : exp0_q.size();
      check($sformatf("dut%0d_done_cycle", which), cyc, exp_done_cyc);
      check($sformatf("dut%0d_fail", which), fl, exp_fail);
      check($sformatf("dut%0d_busy_at_done", which), bsy, 1'b0);
      check($sformatf("dut%0d_ev_missing", which), pend, 0);
      if (which == 1) done_seen1 = 1'b1;
      else            done_seen0 = 1'b1;
    end
  endtask

  always @(negedge clk)
    if (rst_n) mon(1, bus1.ev_valid, bus1.ev_idx, bus1.ev_data, bus1.done, bus1.fail, bus1.busy);
  always @(negedge clk)
    if (rst_n) mon(0, bus0.ev_valid, bus0.ev_idx, bus0.ev_data, bus0.done, bus0.fail, bus0.busy);

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bus1.start = 1'b0;
    bus0.start = 1'b0;
    for (int k = 0; k < T; k++) begin
      el_a[k] = '0; om1_a[k] = '0; om0_a[k] = '0; ex_a[k] = '0;
    end
    for (int k = 0; k <= T; k++) lam_a[k] = '0;
    drive_inputs(0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",     {bus1.busy, bus0.busy}, 2'b00);
    check("rst_valid",    {bus1.ev_valid, bus0.ev_valid}, 2'b00);
    check("rst_idx_data", {bus1.ev_idx, bus1.ev_data, bus0.ev_idx, bus0.ev_data}, '0);
    check("rst_done",     {bus1.done, bus0.done}, 2'b00);
    check("rst_fail",     {bus1.fail, bus0.fail}, 2'b00);
    check("rst_state",    bus1.dbg_state, ST_IDLE);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single error X=2, Lambda'=2, e=0x5A
    el_a  = '{8'h02, 8'h11, 8'h22, 8'h33};
    lam_a = '{8'h01, 8'h02, 8'h00, 8'h00, 8'h00};
    om1_a = '{8'hB4, 8'h00, 8'h00, 8'h00};
    om0_a = '{8'h5A, 8'h00, 8'h00, 8'h00};
    ex_a  = '{8'h5A, 8'h00, 8'h00, 8'h00};
    run_word(1, 1'b0, 0);

    // no errors, plus a start in the done cycle that must be ignored
    run_word(0, 1'b0, 2);
    // more errors than T
    run_word(T + 1, 1'b1, 0);

    // derivative identically zero
    el_a  = '{8'h10, 8'h20, 8'h00, 8'h00};
    lam_a = '{8'h01, 8'h00, 8'h33, 8'h00, 8'h07};
    om1_a = '{8'h5C, 8'h19, 8'h00, 8'h00};
    om0_a = '{8'hA7, 8'h42, 8'h00, 8'h00};
    ex_a  = '{8'h00, 8'h00, 8'h00, 8'h00};
    run_word(2, 1'b1, 0);

    // zero locator
    el_a  = '{8'h00, 8'h00, 8'h00, 8'h00};
    lam_a = '{8'h01, 8'h05, 8'h00, 8'h00, 8'h00};
    om1_a = '{8'h77, 8'h00, 8'h00, 8'h00};
    om0_a = '{8'h77, 8'h00, 8'h00, 8'h00};
    run_word(1, 1'b1, 0);

    // random full and partial words (fail must clear after the bad words)
    for (int r = 0; r < 3; r++) begin
      random_word(T);
      run_word(T, 1'b0, 0);
    end
    for (int r = 1; r < T; r++) begin
      random_word(r);
      run_word(r, 1'b0, 0);
    end

    // start while busy is ignored
    random_word(T);
    run_word(T, 1'b0, 1);

    // abort mid-EVAL, then a normal word
    run_abort(T);
    random_word(T);
    run_word(T, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
